// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin arbiter sharing one ALU datapath between two requesters
//
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   req[1:0]                   request per requester (bit i = requester i)
//   a0/b0/op0, a1/b1/op1       per-requester operands and opcode, sampled on the grant edge
//   gnt[1:0]                   combinational one-hot grant (IDLE or RESP only)
//   alu_a/alu_b/alu_op         operands to the shared ALU (0 in IDLE, held otherwise)
//   alu_result, alu_negative/zero/overflow/carry   shared ALU outputs
//   rsp_valid[1:0]             one-cycle response pulse to the served requester
//   rsp_result, rsp_negative/zero/overflow/carry   registered result and flags
//   busy                       high while an operation is executing
module alu_share_arbiter #(
  parameter int WIDTH   = 64,
  parameter int ALU_LAT = 1,
  parameter int OPW     = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [OPW-1:0]   op0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic [OPW-1:0]   op1,
  output logic [1:0]       gnt,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_negative,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  input  logic             alu_carry,
  output logic [1:0]       rsp_valid,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_negative,
  output logic             rsp_zero,
  output logic             rsp_overflow,
  output logic             rsp_carry,
  output logic             busy
);

  // Counter holds ALU_LAT down to 1, so it needs enough bits for ALU_LAT itself.
  localparam int CW = (ALU_LAT < 2) ? 1 : $clog2(ALU_LAT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             last_served;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] opnd_a;
  logic [WIDTH-1:0] opnd_b;
  logic [OPW-1:0]   opnd_op;

  logic             grant_ok;
  logic             winner;
  logic             do_grant;
  logic             exec_done;

  // Arbitration: a single request wins outright; a tie goes to the requester
  // that was not served last. Grants are suppressed while reset is asserted
  // so an aborting reset never launches a new operation.
  always_comb begin
    grant_ok  = ((state == IDLE) || (state == RESP)) && !reset;
    if (req == 2'b11) begin
      winner = ~last_served;
    end else begin
      winner = req[1];
    end
    do_grant  = grant_ok && (req != 2'b00);
    exec_done = (state == EXEC) && (cnt == CW'(1));
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (do_grant) begin
          state_next = EXEC;
        end
      end
      EXEC: begin
        if (exec_done) begin
          state_next = RESP;
        end
      end
      RESP: begin
        // Back-to-back: a pending request is granted in the response cycle.
        state_next = do_grant ? EXEC : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, latency counter and response registers
  always_ff @(posedge clk) begin
    if (reset) begin
      last_served  <= 1'b1;
      cnt          <= '0;
      opnd_a       <= '0;
      opnd_b       <= '0;
      opnd_op      <= '0;
      rsp_result   <= '0;
      rsp_negative <= 1'b0;
      rsp_zero     <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_carry    <= 1'b0;
    end else begin
      if (do_grant) begin
        opnd_a      <= winner ? a1 : a0;
        opnd_b      <= winner ? b1 : b0;
        opnd_op     <= winner ? op1 : op0;
        last_served <= winner;
        cnt         <= CW'(ALU_LAT);
      end else if (state == EXEC) begin
        cnt <= cnt - CW'(1);
      end
      // The ALU has seen stable inputs for ALU_LAT cycles on the last EXEC cycle.
      if (exec_done) begin
        rsp_result   <= alu_result;
        rsp_negative <= alu_negative;
        rsp_zero     <= alu_zero;
        rsp_overflow <= alu_overflow;
        rsp_carry    <= alu_carry;
      end
    end
  end

  // Outputs
  always_comb begin
    gnt = 2'b00;
    if (do_grant) begin
      gnt = winner ? 2'b10 : 2'b01;
    end
    // last_served still names the finishing operation's owner during RESP;
    // it only moves to a back-to-back winner on the following edge.
    rsp_valid = 2'b00;
    if (state == RESP) begin
      rsp_valid = last_served ? 2'b10 : 2'b01;
    end
    busy = (state == EXEC);
    // Operand registers only change on a grant edge, so RESP naturally keeps
    // the last operation's values on the ALU inputs.
    if (state == IDLE) begin
      alu_a  = '0;
      alu_b  = '0;
      alu_op = '0;
    end else begin
      alu_a  = opnd_a;
      alu_b  = opnd_b;
      alu_op = opnd_op;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - self-checking bench for alu_share_arbiter at ALU_LAT=1 and ALU_LAT=3
module tb_alu_share_arbiter;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [1:0]  req;
  logic [63:0] a0, b0, a1, b1;
  logic [2:0]  op0, op1;

  logic [1:0]  gnt_1, rsp_valid_1, gnt_3, rsp_valid_3;
  logic [63:0] alu_a_1, alu_b_1, alu_result_1, rsp_result_1;
  logic [63:0] alu_a_3, alu_b_3, alu_result_3, rsp_result_3;
  logic [2:0]  alu_op_1, alu_op_3;
  logic        alu_negative_1, alu_zero_1, alu_overflow_1, alu_carry_1;
  logic        alu_negative_3, alu_zero_3, alu_overflow_3, alu_carry_3;
  logic        rsp_negative_1, rsp_zero_1, rsp_overflow_1, rsp_carry_1, busy_1;
  logic        rsp_negative_3, rsp_zero_3, rsp_overflow_3, rsp_carry_3, busy_3;

  // Reference ALU: {negative, zero, overflow, carry, result}
  function automatic logic [67:0] alu_ref(input logic [63:0] a, input logic [63:0] b,
                                          input logic [2:0] op);
    logic [64:0] s;
    logic [63:0] r;
    logic v, c;
    v = 1'b0;
    c = 1'b0;
    case (op)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[63:0];
        c = s[64];
        v = (a[63] == b[63]) && (r[63] != a[63]);
      end
      3'd3: begin
        s = {1'b0, a} + {1'b0, ~b} + 65'd1;
        r = s[63:0];
        c = s[64];
        v = (a[63] != b[63]) && (r[63] != a[63]);
      end
      default: r = a ^ b;
    endcase
    return {r[63], (r == 64'd0), v, c, r};
  endfunction

  // ALU for the single-cycle instance: purely combinational.
  assign {alu_negative_1, alu_zero_1, alu_overflow_1, alu_carry_1, alu_result_1} =
    alu_ref(alu_a_1, alu_b_1, alu_op_1);

  // ALU for the 3-cycle instance: output is only correct after inputs are held 3 cycles.
  logic [67:0] alu3_s1 = '0;
  logic [67:0] alu3_s2 = '0;
  always @(posedge clk) begin
    alu3_s1 <= alu_ref(alu_a_3, alu_b_3, alu_op_3);
    alu3_s2 <= alu3_s1;
  end
  assign {alu_negative_3, alu_zero_3, alu_overflow_3, alu_carry_3, alu_result_3} = alu3_s2;

  alu_share_arbiter #(.WIDTH(64), .ALU_LAT(1), .OPW(3)) u_dut1 (
    .clk(clk), .reset(reset), .req(req),
    .a0(a0), .b0(b0), .op0(op0), .a1(a1), .b1(b1), .op1(op1),
    .gnt(gnt_1), .alu_a(alu_a_1), .alu_b(alu_b_1), .alu_op(alu_op_1),
    .alu_result(alu_result_1), .alu_negative(alu_negative_1), .alu_zero(alu_zero_1),
    .alu_overflow(alu_overflow_1), .alu_carry(alu_carry_1),
    .rsp_valid(rsp_valid_1), .rsp_result(rsp_result_1), .rsp_negative(rsp_negative_1),
    .rsp_zero(rsp_zero_1), .rsp_overflow(rsp_overflow_1), .rsp_carry(rsp_carry_1),
    .busy(busy_1)
  );

  alu_share_arbiter #(.WIDTH(64), .ALU_LAT(3), .OPW(3)) u_dut3 (
    .clk(clk), .reset(reset), .req(req),
    .a0(a0), .b0(b0), .op0(op0), .a1(a1), .b1(b1), .op1(op1),
    .gnt(gnt_3), .alu_a(alu_a_3), .alu_b(alu_b_3), .alu_op(alu_op_3),
    .alu_result(alu_result_3), .alu_negative(alu_negative_3), .alu_zero(alu_zero_3),
    .alu_overflow(alu_overflow_3), .alu_carry(alu_carry_3),
    .rsp_valid(rsp_valid_3), .rsp_result(rsp_result_3), .rsp_negative(rsp_negative_3),
    .rsp_zero(rsp_zero_3), .rsp_overflow(rsp_overflow_3), .rsp_carry(rsp_carry_3),
    .busy(busy_3)
  );

  // Per-instance views for the randomized phase (index 0: ALU_LAT=1, index 1: ALU_LAT=3)
  logic [1:0]  o_gnt [2];
  logic [1:0]  o_rv  [2];
  logic        o_busy[2];
  logic [63:0] o_a   [2];
  logic [63:0] o_b   [2];
  logic [2:0]  o_op  [2];
  logic [67:0] o_rsp [2];
  assign o_gnt[0]  = gnt_1;
  assign o_gnt[1]  = gnt_3;
  assign o_rv[0]   = rsp_valid_1;
  assign o_rv[1]   = rsp_valid_3;
  assign o_busy[0] = busy_1;
  assign o_busy[1] = busy_3;
  assign o_a[0]    = alu_a_1;
  assign o_a[1]    = alu_a_3;
  assign o_b[0]    = alu_b_1;
  assign o_b[1]    = alu_b_3;
  assign o_op[0]   = alu_op_1;
  assign o_op[1]   = alu_op_3;
  assign o_rsp[0]  = {rsp_negative_1, rsp_zero_1, rsp_overflow_1, rsp_carry_1, rsp_result_1};
  assign o_rsp[1]  = {rsp_negative_3, rsp_zero_3, rsp_overflow_3, rsp_carry_3, rsp_result_3};

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [67:0] obs, input logic [67:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req   = 2'b00;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  // Randomized phase: each instance is modelled as "one operation in flight
  // whose response is due at a known cycle" plus a last-served bit.
  task automatic run_random(input int n);
    int          lat     [2];
    bit          inflight[2];
    int          due     [2];
    bit          win     [2];
    bit          last    [2];
    logic [67:0] exp_rsp [2];
    logic [63:0] exp_a   [2];
    logic [63:0] exp_b   [2];
    logic [2:0]  exp_op  [2];
    bit          in_resp, in_exec, w;
    logic [1:0]  eg, er;
    lat[0] = 1;
    lat[1] = 3;
    for (int k = 0; k < 2; k++) begin
      inflight[k] = 1'b0;
      last[k]     = 1'b1;
      due[k]      = 0;
      win[k]      = 1'b0;
    end
    for (int cyc = 0; cyc < n; cyc++) begin
      @(negedge clk);
      req = 2'($urandom_range(0, 3));
      a0  = {$urandom, $urandom};
      b0  = {$urandom, $urandom};
      a1  = {$urandom, $urandom};
      b1  = {$urandom, $urandom};
      op0 = 3'($urandom_range(0, 4));
      op1 = 3'($urandom_range(0, 4));
      #1;
      for (int k = 0; k < 2; k++) begin
        in_resp = inflight[k] && (cyc == due[k]);
        in_exec = inflight[k] && (cyc < due[k]);
        er = in_resp ? (win[k] ? 2'b10 : 2'b01) : 2'b00;
        eg = 2'b00;
        w  = 1'b0;
        if (!in_exec && req != 2'b00) begin
          w  = (req == 2'b11) ? !last[k] : req[1];
          eg = w ? 2'b10 : 2'b01;
        end
        chk("rnd_gnt", o_gnt[k], eg);
        chk("rnd_rsp_valid", o_rv[k], er);
        chk("rnd_busy", o_busy[k], in_exec);
        if (in_resp) chk("rnd_rsp", o_rsp[k], exp_rsp[k]);
        if (in_exec) begin
          chk("rnd_alu_a", o_a[k], exp_a[k]);
          chk("rnd_alu_b", o_b[k], exp_b[k]);
          chk("rnd_alu_op", o_op[k], exp_op[k]);
        end
        if (!inflight[k]) chk("rnd_idle_alu_a", o_a[k], 64'd0);
        if (eg != 2'b00) begin
          inflight[k] = 1'b1;
          win[k]      = w;
          last[k]     = w;
          due[k]      = cyc + lat[k] + 1;
          exp_a[k]    = w ? a1 : a0;
          exp_b[k]    = w ? b1 : b0;
          exp_op[k]   = w ? op1 : op0;
          exp_rsp[k]  = alu_ref(exp_a[k], exp_b[k], exp_op[k]);
        end else if (in_resp) begin
          inflight[k] = 1'b0;
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    req   = 2'b00;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0; op0 = '0; op1 = '0;

    // Reset state and single AND from requester 0; a0 changes after the grant edge.
    do_reset();
    chk("rst_gnt", gnt_1, 2'b00);
    chk("rst_rsp_valid", rsp_valid_1, 2'b00);
    chk("rst_busy", busy_1, 1'b0);
    chk("rst_alu_a", alu_a_1, 64'd0);
    chk("rst_alu_op", alu_op_1, 3'd0);
    chk("rst_rsp", o_rsp[0], 68'd0);
    chk("rst_rsp3", o_rsp[1], 68'd0);
    @(negedge clk);
    req = 2'b01; a0 = 64'hFFFF_0000_FFFF_0000; b0 = 64'h0F0F_0F0F_0F0F_0F0F; op0 = OP_AND;
    #1;
    chk("t1_gnt", gnt_1, 2'b01);
    @(negedge clk);
    req = 2'b00; a0 = 64'h1234_5678_9ABC_DEF0;
    #1;
    chk("t1_busy", busy_1, 1'b1);
    chk("t1_exec_gnt", gnt_1, 2'b00);
    chk("t1_alu_a", alu_a_1, 64'hFFFF_0000_FFFF_0000);
    chk("t1_alu_b", alu_b_1, 64'h0F0F_0F0F_0F0F_0F0F);
    chk("t1_alu_op", alu_op_1, OP_AND);
    @(negedge clk);
    #1;
    chk("t1_rsp_valid", rsp_valid_1, 2'b01);
    chk("t1_rsp_result", rsp_result_1, 64'h0F0F_0000_0F0F_0000);
    chk("t1_rsp_nz", {rsp_negative_1, rsp_zero_1}, 2'b00);
    chk("t1_resp_busy", busy_1, 1'b0);
    @(negedge clk);
    #1;
    chk("t1_after_rsp_valid", rsp_valid_1, 2'b00);
    chk("t1_idle_alu_a", alu_a_1, 64'd0);

    // Fairness with both requesting continuously.
    do_reset();
    a0 = 64'd5;   b0 = 64'd7;  op0 = OP_ADD;
    a1 = 64'd100; b1 = 64'd30; op1 = OP_SUB;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      req = 2'b11;
      #1;
      if (k % 2 == 0) begin
        chk("t2_gnt", gnt_1, ((k / 2) % 2 == 1) ? 2'b10 : 2'b01);
        if (k > 0) begin
          chk("t2_rsp_valid", rsp_valid_1, (((k / 2) - 1) % 2 == 1) ? 2'b10 : 2'b01);
          chk("t2_rsp_result", rsp_result_1, (((k / 2) - 1) % 2 == 1) ? 64'd70 : 64'd12);
        end
      end else begin
        chk("t2_exec_gnt", gnt_1, 2'b00);
        chk("t2_busy", busy_1, 1'b1);
      end
    end

    // Requester 1 AND flag cases, issued back-to-back.
    do_reset();
    @(negedge clk);
    req = 2'b10; a1 = 64'h8000_0000_0000_0001; b1 = 64'h8000_0000_0000_0000; op1 = OP_AND;
    #1;
    chk("t3_gnt", gnt_1, 2'b10);
    @(negedge clk);
    a1 = 64'hAAAA_AAAA_AAAA_AAAA; b1 = 64'h5555_5555_5555_5555;
    #1;
    @(negedge clk);
    #1;
    chk("t3_rsp_valid", rsp_valid_1, 2'b10);
    chk("t3_rsp_result", rsp_result_1, 64'h8000_0000_0000_0000);
    chk("t3_rsp_nz", {rsp_negative_1, rsp_zero_1}, 2'b10);
    chk("t3_b2b_gnt", gnt_1, 2'b10);
    @(negedge clk);
    req = 2'b00;
    #1;
    @(negedge clk);
    #1;
    chk("t3_rsp_valid2", rsp_valid_1, 2'b10);
    chk("t3_rsp_result2", rsp_result_1, 64'd0);
    chk("t3_rsp_nz2", {rsp_negative_1, rsp_zero_1}, 2'b01);

    // ALU_LAT=3 latency, EXEC blocking and back-to-back grant.
    do_reset();
    @(negedge clk);
    req = 2'b01; a0 = 64'd3; b0 = 64'd4; op0 = OP_ADD;
    #1;
    chk("t4_gnt", gnt_3, 2'b01);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      req = 2'b10; a1 = 64'd9; b1 = 64'd1; op1 = OP_SUB;
      #1;
      chk("t4_busy", busy_3, 1'b1);
      chk("t4_exec_gnt", gnt_3, 2'b00);
      chk("t4_exec_rsp_valid", rsp_valid_3, 2'b00);
      chk("t4_alu_a", alu_a_3, 64'd3);
    end
    @(negedge clk);
    #1;
    chk("t4_rsp_valid", rsp_valid_3, 2'b01);
    chk("t4_rsp_result", rsp_result_3, 64'd7);
    chk("t4_b2b_gnt", gnt_3, 2'b10);
    for (int k = 5; k <= 7; k++) begin
      @(negedge clk);
      req = 2'b00;
      #1;
      chk("t4_busy2", busy_3, 1'b1);
      chk("t4_exec_rsp_valid2", rsp_valid_3, 2'b00);
    end
    @(negedge clk);
    #1;
    chk("t4_rsp_valid2", rsp_valid_3, 2'b10);
    chk("t4_rsp_result2", rsp_result_3, 64'd8);

    // Reset pulse during EXEC aborts the operation without a response.
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      req = 2'b00;
    end
    @(negedge clk);
    req = 2'b01; a0 = 64'd11; b0 = 64'd22; op0 = OP_ADD;
    #1;
    chk("t5_gnt1", gnt_1, 2'b01);
    chk("t5_gnt3", gnt_3, 2'b01);
    @(negedge clk);
    req = 2'b00; reset = 1'b1;
    #1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("t5_busy1", busy_1, 1'b0);
    chk("t5_busy3", busy_3, 1'b0);
    chk("t5_rsp1", o_rsp[0], 68'd0);
    chk("t5_rsp3", o_rsp[1], 68'd0);
    chk("t5_alu_a1", alu_a_1, 64'd0);
    chk("t5_alu_a3", alu_a_3, 64'd0);
    for (int k = 0; k < 5; k++) begin
      chk("t5_no_rsp1", rsp_valid_1, 2'b00);
      chk("t5_no_rsp3", rsp_valid_3, 2'b00);
      @(negedge clk);
      #1;
    end
    @(negedge clk);
    req = 2'b11;
    #1;
    chk("t5_tie_gnt1", gnt_1, 2'b01);
    chk("t5_tie_gnt3", gnt_3, 2'b01);

    // Randomized traffic against the reference model on both instances.
    do_reset();
    run_random(400);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Shares one 64-bit ALU datapath (AND/ORR/ADD/SUB-class units with negative/zero/overflow/carry flags) between two requesters, e.g. the EX stage and a multi-cycle helper unit. It arbitrates round-robin and latches the winner's operands and opcode. It drives the ALU for a fixed number of cycles, captures result and flags, and returns them to the winner with a one-cycle valid pulse. Only one operation is in flight at a time.

Parameters:
WIDTH, 64, operand/result width.
ALU_LAT, 1, cycles the shared ALU needs from stable inputs to valid outputs; must be >= 1.
OPW, 3, ALU opcode width.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
req  input  2  request per requester; bit i = requester i.
a0, b0  input  WIDTH each  requester 0 operands.
op0  input  OPW  requester 0 opcode.
a1, b1  input  WIDTH each  requester 1 operands.
op1  input  OPW  requester 1 opcode.
gnt  output  2  one-hot grant, combinational, at most one bit set.
alu_a, alu_b  output  WIDTH each  operands to the shared ALU.
alu_op  output  OPW  opcode to the shared ALU.
alu_result  input  WIDTH  ALU result.
alu_negative, alu_zero, alu_overflow, alu_carry  input  1 each  ALU flags.
rsp_valid  output  2  one-cycle response pulse to requester i.
rsp_result  output  WIDTH  registered result.
rsp_negative, rsp_zero, rsp_overflow, rsp_carry  output  1 each  registered flags.
busy  output  1  high while the FSM is in EXEC.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high.
- States: IDLE, EXEC, RESP. Encoding is free.
- Reset values:
  - state=IDLE, gnt=0, rsp_valid=0, rsp_result=0, all rsp flags=0.
  - alu_a=0, alu_b=0, alu_op=0, busy=0.
  - last_served=1, so requester 0 wins the first tie.
- Grant:
  - Granting is allowed only in IDLE or RESP, and only when reset is low.
  - One req bit set: grant it.
  - Both set: grant !last_served.
  - On the grant edge, latch the winner's a/b/op into operand registers, set last_served=winner, set the counter to ALU_LAT, go to EXEC.
- Request protocol:
  - Operands are sampled only on the grant edge; they may change afterwards.
  - req held in the cycle after gnt counts as a new request.
  - Dropping req before grant is legal and has no effect.
- alu_a/alu_b/alu_op are driven from the operand registers in EXEC and held for all ALU_LAT cycles. They read 0 in IDLE. In RESP they keep their last values.
- EXEC:
  - The counter decrements each cycle.
  - On the cycle the counter==1, capture alu_result and the four flags into the rsp registers and go to RESP.
- RESP (exactly one cycle):
  - rsp_valid[winner]=1.
  - If a request is pending, grant it in this same cycle (back-to-back) and go to EXEC; otherwise go to IDLE.
- Timing:
  - Latency: gnt high in cycle t, rsp_valid high in cycle t+ALU_LAT+1.
  - Throughput: one operation per ALU_LAT+1 cycles.
- rsp_result and the flags hold their values until the next capture. They are meaningful only while rsp_valid is set.
- Requests arriving during EXEC wait. gnt=0 throughout EXEC.
- Reset mid-operation: abort immediately. No rsp_valid is issued for the aborted operation, and all state returns to its reset values.
- Fairness: with both requesters continuously asserting, grants alternate 0,1,0,1,...

Test Plan:
1. After reset, req=01, a0=64'hFFFF_0000_FFFF_0000, b0=64'h0F0F_0F0F_0F0F_0F0F, op0=AND, ALU_LAT=1, bench ALU models AND -> gnt=01 at t, alu_a/alu_b match the operands during EXEC, rsp_valid=01 at t+2, rsp_result=64'h0F0F_0000_0F0F_0000, negative=0, zero=0.
2. req=11 held continuously, ALU_LAT=1 -> grants 01,10,01,10 every 2 cycles, starting with 01. Each rsp_valid goes to the matching requester with that requester's result.
3. Requester 1 does AND with a1=64'h8000_0000_0000_0001, b1=64'h8000_0000_0000_0000 -> rsp_result=64'h8000_0000_0000_0000, rsp_negative=1, rsp_zero=0. Then a1=64'hAAAA..., b1=64'h5555... -> rsp_zero=1, rsp_negative=0.
4. ALU_LAT=3, req=01 at t -> busy high for t+1..t+3, gnt=00 during EXEC even though req=10 arrives at t+1, rsp_valid=01 at t+4, gnt=10 also at t+4 (back-to-back), second rsp_valid=10 at t+8.
5. Requester 0 is granted, then reset pulses for one cycle during EXEC -> no rsp_valid ever issued. Outputs and last_served read their reset values. The next req=11 grants requester 0.
6. a0 changed in the cycle after gnt -> rsp_result reflects the operands sampled at the grant edge.
